// File: rtl/seq_alu.sv
// Sequential ALU: registered single-cycle base ops plus iterative MUL/DIVU/REMU behind valid/ready.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise modes 10/11 complete at once as illegal.

package seq_alu_pkg;
  typedef enum logic [3:0] {
    AluAnd  = 4'd0,
    AluOr   = 4'd1,
    AluXor  = 4'd2,
    AluSll  = 4'd3,
    AluSrl  = 4'd4,
    AluSra  = 4'd5,
    AluAdd  = 4'd6,
    AluSub  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_control_t;
endpackage

module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_control_t control,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         zero,
  output logic         equal,
  output logic         illegal
);

  localparam int unsigned ShW  = $clog2(N);
  localparam int unsigned CntW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e state_q, state_d;

  logic [N-1:0]    result_q, hi_q, lo_q, a_q;
  logic            overflow_q, zero_q, equal_q, illegal_q;
  logic [CntW-1:0] cnt_q;
`ifdef SEQ_ALU_DIV_EN
  logic [N-1:0]    b_q;
  logic [1:0]      mode_q;
  logic [N:0]      div_shift, div_diff;
  logic            div_ge;
`endif

  logic            accept, is_multi, busy_last;
  logic [N-1:0]    base_res, add_res, sub_res;
  logic            base_ovf;
  logic [ShW-1:0]  shamt;
  logic [N:0]      mul_sum, mul_step;

  assign accept    = in_valid && in_ready;
  assign busy_last = (cnt_q == CntW'(N));
`ifdef SEQ_ALU_DIV_EN
  assign is_multi  = (mode != 2'b00);
`else
  assign is_multi  = (mode == 2'b01);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = is_multi ? StBusy : StDone;
      StBusy: if (busy_last) state_d = StDone;
      StDone: begin
        if (accept)         state_d = is_multi ? StBusy : StDone;
        else if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = !rst && (state_q == StIdle || (state_q == StDone && out_ready));
    out_valid = (state_q == StDone);
    result    = result_q;
    overflow  = overflow_q;
    zero      = zero_q;
    equal     = equal_q;
    illegal   = illegal_q;
  end

  // Single-cycle operation set, evaluated on the live inputs at the accept edge
  always_comb begin
    add_res  = a + b;
    sub_res  = a - b;
    shamt    = b[ShW-1:0];
    base_res = '0;
    base_ovf = 1'b0;
    case (control)
      AluAnd:  base_res = a & b;
      AluOr:   base_res = a | b;
      AluXor:  base_res = a ^ b;
      AluSll:  base_res = a << shamt;
      AluSrl:  base_res = a >> shamt;
      AluSra:  base_res = $signed(a) >>> shamt;
      AluAdd: begin
        base_res = add_res;
        base_ovf = (a[N-1] == b[N-1]) && (add_res[N-1] != a[N-1]);
      end
      AluSub: begin
        base_res = sub_res;
        base_ovf = (a[N-1] != b[N-1]) && (sub_res[N-1] != a[N-1]);
      end
      AluSlt:  base_res = N'($signed(a) < $signed(b));
      AluSltu: base_res = N'(a < b);
      default: base_res = '0;
    endcase
  end

  // Shift-add step: hi accumulates, lo holds the remaining multiplier bits
  assign mul_sum  = {1'b0, hi_q} + {1'b0, a_q};
  assign mul_step = lo_q[0] ? mul_sum : {1'b0, hi_q};

`ifdef SEQ_ALU_DIV_EN
  // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in
  assign div_shift = {hi_q, lo_q[N-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift - {1'b0, b_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      equal_q    <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      a_q        <= '0;
`ifdef SEQ_ALU_DIV_EN
      b_q        <= '0;
      mode_q     <= 2'b00;
`endif
    end else if (accept) begin
      equal_q <= (a == b);
      cnt_q   <= '0;
`ifdef SEQ_ALU_DIV_EN
      mode_q  <= mode;
`endif
      case (mode)
        2'b00: begin
          result_q   <= base_res;
          overflow_q <= base_ovf;
          zero_q     <= (base_res == '0);
          illegal_q  <= 1'b0;
        end
        2'b01: begin
          a_q  <= a;
          hi_q <= '0;
          lo_q <= b;
        end
        default: begin
`ifdef SEQ_ALU_DIV_EN
          b_q  <= b;
          hi_q <= '0;
          lo_q <= a;
`else
          result_q   <= '0;
          overflow_q <= 1'b0;
          zero_q     <= 1'b1;
          illegal_q  <= 1'b1;
`endif
        end
      endcase
    end else if (state_q == StBusy) begin
      if (busy_last) begin
        illegal_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
        if (mode_q != 2'b01) begin
          result_q   <= (mode_q == 2'b10) ? lo_q : hi_q;
          overflow_q <= 1'b0;
          zero_q     <= (((mode_q == 2'b10) ? lo_q : hi_q) == '0);
        end else
`endif
        begin
          result_q   <= lo_q;
          overflow_q <= (hi_q != '0);
          zero_q     <= (lo_q == '0);
        end
      end else begin
        cnt_q <= cnt_q + CntW'(1);
`ifdef SEQ_ALU_DIV_EN
        if (mode_q != 2'b01) begin
          hi_q <= div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
          lo_q <= {lo_q[N-2:0], div_ge};
        end else
`endif
        begin
          hi_q <= mul_step[N:1];
          lo_q <= {mul_step[0], lo_q[N-1:1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (N=32); honours SEQ_ALU_DIV_EN like the design.

module tb_seq_alu;
  import seq_alu_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  a, b;
  alu_control_t control;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  result;
  logic         overflow, zero, equal, illegal;

  int checks   = 0;
  int failures = 0;
  int cycles;
  int rises;

  seq_alu #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .control   (control),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .zero      (zero),
    .equal     (equal),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic base_op(input alu_control_t c, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    control  = c;
    mode     = 2'b00;
    a        = x;
    b        = y;
  endtask

  // Counts clock edges after the accept edge until out_valid, bounded
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 32'd5;
    b         = 32'd5;
    control   = AluAdd;
    mode      = 2'b00;

    // Reset with an operation offered
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, overflow, zero, equal, illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Signed overflow cases and compares
    base_op(AluAdd, 32'h7FFF_FFFF, 32'd1);
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", {31'd0, overflow}, 32'd1);
    base_op(AluSub, 32'h8000_0000, 32'd1);
    tick();
    chk("sub_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf", {31'd0, overflow}, 32'd1);
    base_op(AluSltu, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("sltu_result", result, 32'd1);
    chk("sltu_ovf", {31'd0, overflow}, 32'd0);
    base_op(AluSlt, 32'd1, 32'hFFFF_FFFF);
    tick();
    chk("slt_pos_neg", result, 32'd0);
    chk("slt_zero_flag", {31'd0, zero}, 32'd1);
    base_op(AluSlt, 32'h8000_0000, 32'd1);
    tick();
    chk("slt_ovf_case", result, 32'd1);

    // Back-to-back base ops, one result per cycle
    base_op(AluAnd, 32'hF0F0_F0F0, 32'hFF00_FF00);
    tick();
    chk("b2b_and", result, 32'hF000_F000);
    base_op(AluOr, 32'h0000_0F00, 32'h0000_00F0);
    tick();
    chk("b2b_or", result, 32'h0000_0FF0);
    base_op(AluXor, 32'hFFFF_0000, 32'h0FF0_0FF0);
    tick();
    chk("b2b_xor", result, 32'hF00F_0FF0);
    base_op(AluSll, 32'd1, 32'h0000_0024);
    tick();
    chk("b2b_sll_masked", result, 32'h0000_0010);
    base_op(AluSra, 32'h8000_0000, 32'd31);
    tick();
    chk("b2b_sra", result, 32'hFFFF_FFFF);
    base_op(AluSrl, 32'h8000_0000, 32'd31);
    tick();
    chk("b2b_srl", result, 32'd1);
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);

    // Stall: consumer not ready
    base_op(AluAdd, 32'd3, 32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("stall_result", result, 32'd1);
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("stall_release", result, 32'd7);
    in_valid = 1'b0;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 32'd0);

    // MUL with overflow
    in_valid = 1'b1;
    mode     = 2'b01;
    a        = 32'h0001_0000;
    b        = 32'h0001_0000;
    tick();
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    chk("mul_busy_in_ready", {31'd0, in_ready}, 32'd0);
    wait_done(cycles);
    chk("mul1_latency", cycles, 32'd33);
    chk("mul1_result", result, 32'd0);
    chk("mul1_zero", {31'd0, zero}, 32'd1);
    chk("mul1_ovf", {31'd0, overflow}, 32'd1);
    chk("mul1_equal", {31'd0, equal}, 32'd1);

    in_valid = 1'b1;
    mode     = 2'b01;
    a        = 32'd7;
    b        = 32'd6;
    tick();
    in_valid = 1'b0;
    wait_done(cycles);
    chk("mul2_latency", cycles, 32'd33);
    chk("mul2_result", result, 32'd42);
    chk("mul2_ovf", {31'd0, overflow}, 32'd0);

`ifdef SEQ_ALU_DIV_EN
    in_valid = 1'b1; mode = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    in_valid = 1'b0;
    wait_done(cycles);
    chk("divu_latency", cycles, 32'd33);
    chk("divu_result", result, 32'd14);
    chk("divu_illegal", {31'd0, illegal}, 32'd0);
    in_valid = 1'b1; mode = 2'b11; a = 32'd100; b = 32'd7;
    tick();
    in_valid = 1'b0;
    wait_done(cycles);
    chk("remu_result", result, 32'd2);
    in_valid = 1'b1; mode = 2'b10; a = 32'd100; b = 32'd0;
    tick();
    in_valid = 1'b0;
    wait_done(cycles);
    chk("divu0_latency", cycles, 32'd33);
    chk("divu0_result", result, 32'hFFFF_FFFF);
    chk("divu0_ovf", {31'd0, overflow}, 32'd0);
    in_valid = 1'b1; mode = 2'b11; a = 32'd100; b = 32'd0;
    tick();
    in_valid = 1'b0;
    wait_done(cycles);
    chk("remu0_result", result, 32'd100);
`else
    in_valid = 1'b1; mode = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    chk("divu_ill_valid", {31'd0, out_valid}, 32'd1);
    chk("divu_ill_result", result, 32'd0);
    chk("divu_ill_flags", {28'd0, overflow, zero, equal, illegal}, 32'b0101);
    mode = 2'b11;
    tick();
    chk("remu_ill_result", result, 32'd0);
    chk("remu_ill_illegal", {31'd0, illegal}, 32'd1);
    in_valid = 1'b0;
`endif

    // Reset during the 10th BUSY cycle of a MUL
    in_valid = 1'b1; mode = 2'b01; a = 32'd5; b = 32'd9;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) rises++;
    end
    chk("abort_no_result", rises, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    base_op(AluAdd, 32'd3, 32'd4);
    tick();
    in_valid = 1'b0;
    chk("post_abort_valid", {31'd0, out_valid}, 32'd1);
    chk("post_abort_add", result, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
